conv_dot_engine: RTL

- Parametrised, multi-cycle dot-product engine for 2-D convolution windows.
- Computes one N_ELEM-element IFM window against a runtime-loadable weight set, LANES multipliers per cycle, supporting unsigned or signed operands.
- Sits between the IFM streamer and the OFM writeback buffer.
- Uses valid/ready handshakes on both sides.

---
 rtl/conv_dot_engine.sv | 134 +++++++++++++
 1 files changed

// File: rtl/conv_dot_engine.sv
// Multi-cycle dot-product engine: one N_ELEM-element IFM window against a
// runtime-loadable weight set, LANES products per accepted beat.
module conv_dot_engine #(
  parameter int DATA_W = 4,
  parameter int N_ELEM = 32,
  parameter int LANES  = 8,
  parameter int OUT_W  = 13
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      w_we,
  input  logic [$clog2(N_ELEM)-1:0] w_addr,
  input  logic [DATA_W-1:0]         w_data,
  input  logic                      signed_en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic                      busy
);

  localparam int BEATS  = N_ELEM / LANES;
  localparam int ADDR_W = $clog2(N_ELEM);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [OUT_W-1:0]    acc_q, acc_d;
  logic [OUT_W-1:0]    out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                mode_q, mode_d;
  logic [DATA_W-1:0]   weight_q [N_ELEM];
  logic [DATA_W-1:0]   weight_d [N_ELEM];

  logic                mode_eff;
  logic                accept;
  logic                last_beat;
  logic [DATA_W-1:0]   a_l, w_l;
  logic [OUT_W-1:0]    a_ext, w_ext;
  logic [ADDR_W-1:0]   idx;
  logic [OUT_W-1:0]    psum;
  logic [OUT_W-1:0]    sum;

  assign in_ready  = (state_q != S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign accept    = in_valid & in_ready;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  // The first beat has no latched mode yet, so it uses signed_en directly.
  assign mode_eff = (state_q == S_IDLE) ? signed_en : mode_q;

  always_comb begin
    psum  = '0;
    a_l   = '0;
    w_l   = '0;
    a_ext = '0;
    w_ext = '0;
    idx   = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      a_l   = in_data[l*DATA_W +: DATA_W];
      idx   = ADDR_W'(beat_q * LANES + l);
      w_l   = weight_q[idx];
      a_ext = {{(OUT_W-DATA_W){mode_eff & a_l[DATA_W-1]}}, a_l};
      w_ext = {{(OUT_W-DATA_W){mode_eff & w_l[DATA_W-1]}}, w_l};
      psum  = psum + a_ext * w_ext;
    end
  end

  // A fresh window starts from a zero accumulator rather than clearing it on exit.
  assign sum = ((state_q == S_IDLE) ? '0 : acc_q) + psum;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    mode_d      = mode_q;
    weight_d    = weight_q;
    case (state_q)
      S_IDLE, S_ACC: begin
        if (accept) begin
          if (state_q == S_IDLE) mode_d = signed_en;
          if (last_beat) begin
            out_data_d  = sum;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
          end else begin
            acc_d   = sum;
            beat_d  = beat_q + 1'b1;
            state_d = S_ACC;
          end
        end else if (state_q == S_IDLE && w_we && int'(w_addr) < N_ELEM) begin
          weight_d[w_addr] = w_data;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          beat_d      = '0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      mode_q      <= 1'b0;
      weight_q    <= '{default: '0};
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      mode_q      <= mode_d;
      weight_q    <= weight_d;
    end
  end

endmodule
